reg_40b_readout: RTL and testbench
==================================

# reg_40b_readout

Read-side companion to the 40-bit preset/enable register: on a request, it snapshots a 40-bit register value and streams it out as five bytes over a valid/ready handshake. It sits between the 40-bit state registers and the debug/readback byte channel. Software and test logic use it to observe wide register contents through an 8-bit path without a 40-bit bus.

## Interface
- LSB_FIRST, 1, byte order: 1 sends [7:0] first and [39:32] last; 0 sends [39:32] first.
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  40  register value to read; sampled only at request acceptance.
- req_valid  input  1  readback request.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid & req_ready at an edge.
- out_data  output  8  current byte; 8'h00 whenever out_valid=0.
- out_valid  output  1  byte available.
- out_ready  input  1  consumer accepts the byte when out_valid & out_ready at an edge.
- out_last  output  1  high with out_valid on the fifth byte only.
- busy  output  1  high in SEND.
- out_par  output  1  present only with the parity macro (see Configuration).

## Operation
- States: IDLE, SEND.
- IDLE:
  - req_ready=1.
  - On accept: snapshot <= in, cnt <= 0, go to SEND.
- SEND:
  - out_valid=1.
  - out_data = snapshot byte index cnt when LSB_FIRST=1; otherwise index 4-cnt.
  - On out_valid & out_ready: if cnt==4, go to IDLE; otherwise cnt <= cnt+1.
- cnt is 3 bits and takes values 0..4 only. Values 5..7 are unreachable; if one is reached, go to IDLE.
- Stall rule: out_data and out_last stay stable while out_valid=1 and out_ready=0.
- in changing during SEND has no effect; the snapshot is frozen until the next accept.
- req_valid during SEND is ignored (req_ready=0); it is not queued.
- Snapshot register: loads only at accept; not cleared on completion.

## Timing
- Reset values:
  - state=IDLE, cnt=0, snapshot=40'hFF_FFFF_FFFF.
  - req_ready=1, out_valid=0, out_data=8'h00, out_last=0, busy=0, out_par=0.
- Request accepted at edge T: out_valid=1 from T+1 with the first byte.
- With out_ready held at 1:
  - Bytes are transferred at edges T+1..T+5.
  - req_ready=1 again in cycle T+6.
  - Minimum request-to-request spacing is 6 cycles.
- Back-pressure adds one cycle per stalled cycle; there is no timeout.
- A request is not accepted in the same cycle as the last byte's acceptance. req_ready rises the cycle after.
- rst during SEND:
  - The transfer is dropped; state returns to IDLE at the next edge.
  - The snapshot returns to all-ones.
  - No out_last is emitted.
- Simultaneous rst and req_valid: rst wins and the request is not accepted.

## Configuration
- REG40_READOUT_PARITY_EN defined:
  - Adds the out_par port.
  - out_par is the even-parity bit (XOR of the 8 bits) of out_data while out_valid=1, and 0 otherwise.
  - Parity is combinational from the snapshot byte and holds stable under stall.
- Macro undefined: no out_par port and no parity logic; all other behaviour is identical.

## Structure
- Shared package holds:
  - the constants REG40_W=40, REG40_BYTE_W=8, REG40_NBYTES=5, REG40_CNT_W=3;
  - the state typedef (IDLE, SEND);
  - the reset constant REG40_SNAP_RST=40'hFF_FFFF_FFFF.
- One sub-module: the snapshot is an instance of reg_40b_set, with wr_en = accept and set = rst. This gives the all-ones reset value.
- The FSM, counter and byte mux live in the top module.

## Test plan
- Basic: reset, then req with in=40'h12_3456_789A, out_ready=1 → bytes 9A,78,56,34,12 at T+1..T+5; out_last only on 12; req_ready=1 at T+6.
- Byte order: LSB_FIRST=0, same input → bytes 12,34,56,78,9A; out_last on 9A.
- Stall and isolation:
  - out_ready=0 for 3 cycles on byte 2 → out_data holds 56 for the whole stall.
  - in changes to 0 during the transfer → the remaining bytes still come from the snapshot.
  - req_valid held high during SEND → no second transfer starts before T+6 + stall.
- Reset mid-transfer: rst after byte 1 → next cycle IDLE, out_valid=0, out_data=00, snapshot all-ones; a new request with in=40'hA5_A5A5_A5A5 streams five A5 bytes.
- Parity (macro defined): in=40'h00_0103_07FF → out_par sequence 0,1,0,1,0. With the macro undefined, the port is absent and the same data is produced.

Source files
------------

// File: rtl/reg_40b_readout_pkg.sv
// Shared constants and state type for the 40-bit register byte readout.
package reg_40b_readout_pkg;

    localparam int REG40_W      = 40;
    localparam int REG40_BYTE_W = 8;
    localparam int REG40_NBYTES = 5;
    localparam int REG40_CNT_W  = 3;

    localparam logic [REG40_W-1:0]     REG40_SNAP_RST = 40'hFF_FFFF_FFFF;
    localparam logic [REG40_CNT_W-1:0] REG40_CNT_LAST = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } reg40_state_t;

endpackage

// File: rtl/reg_40b_set.sv
// Wide register with synchronous set-to-constant and write enable; set has priority.
module reg_40b_set
    import reg_40b_readout_pkg::*;
#(
    parameter int              W       = REG40_W,
    parameter logic [W-1:0]    SET_VAL = REG40_SNAP_RST
) (
    input  logic         clk,
    input  logic         set,
    input  logic         wr_en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (set) begin
            q <= SET_VAL;
        end else if (wr_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_40b_readout.sv
// Snapshots a 40-bit value on request and streams it as five bytes over valid/ready.
// Optional even-parity output enabled by defining REG40_READOUT_PARITY_EN.
module reg_40b_readout
    import reg_40b_readout_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG40_W-1:0]      in,
    input  logic                    req_valid,
    output logic                    req_ready,
    output logic [REG40_BYTE_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
`ifdef REG40_READOUT_PARITY_EN
    output logic                    out_par,
`endif
    output logic                    busy
);

    reg40_state_t                               state_reg, state_next;
    logic [REG40_CNT_W-1:0]                     cnt_reg, cnt_next;
    logic [REG40_CNT_W-1:0]                     byte_idx;
    logic [REG40_W-1:0]                         snap_q;
    logic [REG40_NBYTES-1:0][REG40_BYTE_W-1:0]  snap_bytes;
    logic                                       accept;

    // The FSM reset overrides accept, so a request coinciding with rst is dropped.
    assign accept = req_valid && (state_reg == IDLE);

    reg_40b_set #(
        .W       (REG40_W),
        .SET_VAL (REG40_SNAP_RST)
    ) u_snap (
        .clk   (clk),
        .set   (rst),
        .wr_en (accept),
        .d     (in),
        .q     (snap_q)
    );

    genvar gi;
    generate
        for (gi = 0; gi < REG40_NBYTES; gi++) begin : g_bytes
            assign snap_bytes[gi] = snap_q[gi*REG40_BYTE_W +: REG40_BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = SEND;
                    cnt_next   = '0;
                end
            end
            SEND: begin
                busy = 1'b1;
                // Out-of-range count can only come from an upset; abandon the transfer.
                if (cnt_reg > REG40_CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    out_valid = 1'b1;
                    out_last  = (cnt_reg == REG40_CNT_LAST);
                    if (out_ready) begin
                        if (cnt_reg == REG40_CNT_LAST) begin
                            state_next = IDLE;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        byte_idx = LSB_FIRST ? cnt_reg : (REG40_CNT_LAST - cnt_reg);
        out_data = '0;
        if (out_valid && (byte_idx <= REG40_CNT_LAST)) begin
            out_data = snap_bytes[byte_idx];
        end
    end

`ifdef REG40_READOUT_PARITY_EN
    // out_data is zero when idle, so this is 0 whenever out_valid is low.
    assign out_par = ^out_data;
`endif

endmodule

// File: tb/tb_reg_40b_readout.sv
// Directed table plus randomized transfers for reg_40b_readout in both byte orders.
module tb_reg_40b_readout;
    import reg_40b_readout_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        out_ready;
    logic [39:0] in_val;

    logic        req_ready_l, out_valid_l, out_last_l, busy_l;
    logic [7:0]  out_data_l;
    logic        req_ready_m, out_valid_m, out_last_m, busy_m;
    logic [7:0]  out_data_m;
`ifdef REG40_READOUT_PARITY_EN
    logic        out_par_l, out_par_m;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_40b_readout #(.LSB_FIRST(1'b1)) dut_l (
        .clk       (clk),
        .rst       (rst),
        .in        (in_val),
        .req_valid (req_valid),
        .req_ready (req_ready_l),
        .out_data  (out_data_l),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .out_last  (out_last_l),
`ifdef REG40_READOUT_PARITY_EN
        .out_par   (out_par_l),
`endif
        .busy      (busy_l)
    );

    reg_40b_readout #(.LSB_FIRST(1'b0)) dut_m (
        .clk       (clk),
        .rst       (rst),
        .in        (in_val),
        .req_valid (req_valid),
        .req_ready (req_ready_m),
        .out_data  (out_data_m),
        .out_valid (out_valid_m),
        .out_ready (out_ready),
        .out_last  (out_last_m),
`ifdef REG40_READOUT_PARITY_EN
        .out_par   (out_par_m),
`endif
        .busy      (busy_m)
    );

    typedef struct {
        logic [39:0] val;
        int          stall_at;
        int          stall_len;
        bit          change_in;
        bit          hold_req;
        logic [39:0] exp_seq;   // LSB-first transmission order, first byte in [39:32]
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the LSB-first stream is the value's bytes from least to most significant.
    function automatic logic [39:0] model_seq(input logic [39:0] v);
        logic [39:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r = (r << 8) | ((v >> (8 * k)) & 40'hFF);
        end
        return r;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, " req_ready_l"}, 64'(req_ready_l), 64'(1));
        chk({tag, " req_ready_m"}, 64'(req_ready_m), 64'(1));
        chk({tag, " out_valid_l"}, 64'(out_valid_l), 64'(0));
        chk({tag, " out_valid_m"}, 64'(out_valid_m), 64'(0));
        chk({tag, " out_data_l"},  64'(out_data_l),  64'(0));
        chk({tag, " out_data_m"},  64'(out_data_m),  64'(0));
        chk({tag, " out_last_l"},  64'(out_last_l),  64'(0));
        chk({tag, " busy_l"},      64'(busy_l),      64'(0));
`ifdef REG40_READOUT_PARITY_EN
        chk({tag, " out_par_l"},   64'(out_par_l),   64'(0));
`endif
    endtask

    task automatic check_byte(input string tag, input logic [39:0] exp_seq, input int pos);
        logic [7:0] eb_l;
        logic [7:0] eb_m;
        eb_l = exp_seq[39 - 8*pos -: 8];
        eb_m = exp_seq[8*pos +: 8];
        chk($sformatf("%s b%0d valid_l", tag, pos), 64'(out_valid_l), 64'(1));
        chk($sformatf("%s b%0d valid_m", tag, pos), 64'(out_valid_m), 64'(1));
        chk($sformatf("%s b%0d data_l", tag, pos),  64'(out_data_l),  64'(eb_l));
        chk($sformatf("%s b%0d data_m", tag, pos),  64'(out_data_m),  64'(eb_m));
        chk($sformatf("%s b%0d last_l", tag, pos),  64'(out_last_l),  64'(pos == 4));
        chk($sformatf("%s b%0d last_m", tag, pos),  64'(out_last_m),  64'(pos == 4));
        chk($sformatf("%s b%0d req_ready", tag, pos), 64'(req_ready_l), 64'(0));
        chk($sformatf("%s b%0d busy", tag, pos),    64'(busy_l),      64'(1));
`ifdef REG40_READOUT_PARITY_EN
        chk($sformatf("%s b%0d par_l", tag, pos),   64'(out_par_l),   64'(^eb_l));
        chk($sformatf("%s b%0d par_m", tag, pos),   64'(out_par_m),   64'(^eb_m));
`endif
    endtask

    task automatic run_xfer(input vec_t t, input string tag);
        check_idle({tag, " pre"});
        in_val    = t.val;
        req_valid = 1'b1;
        out_ready = 1'b1;
        step();
        req_valid = t.hold_req;
        if (t.change_in) in_val = 40'h0;
        for (int pos = 0; pos < 5; pos++) begin
            if (pos == t.stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < t.stall_len; s++) begin
                    check_byte({tag, " stall"}, t.exp_seq, pos);
                    step();
                end
                out_ready = 1'b1;
            end
            check_byte(tag, t.exp_seq, pos);
            step();
        end
        req_valid = 1'b0;
        check_idle({tag, " post"});
        $display("xfer %s val=%010h stall_at=%0d len=%0d chg=%0d hold=%0d",
                 tag, t.val, t.stall_at, t.stall_len, t.change_in, t.hold_req);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        vec_t rv;

        tbl[0] = '{40'h12_3456_789A, 5, 0, 1'b0, 1'b0, 40'h9A_7856_3412};
        tbl[1] = '{40'h12_3456_789A, 2, 3, 1'b0, 1'b0, 40'h9A_7856_3412};
        tbl[2] = '{40'h12_3456_789A, 1, 1, 1'b1, 1'b0, 40'h9A_7856_3412};
        tbl[3] = '{40'h12_3456_789A, 3, 2, 1'b0, 1'b1, 40'h9A_7856_3412};
        tbl[4] = '{40'h00_0103_07FF, 5, 0, 1'b0, 1'b0, 40'hFF_0703_0100};
        tbl[5] = '{40'hA5_A5A5_A5A5, 5, 0, 1'b0, 1'b0, 40'hA5_A5A5_A5A5};

        rst = 1'b1; req_valid = 1'b0; out_ready = 1'b1; in_val = 40'h0;
        step(); step();
        chk("reset snap", 64'(dut_l.snap_q), 64'(40'hFF_FFFF_FFFF));
        check_idle("reset");
        rst = 1'b0;
        $display("reset applied");

        for (int i = 0; i < 5; i++) run_xfer(tbl[i], $sformatf("tbl%0d", i));

        // Reset in the middle of a transfer, after the first byte is taken.
        in_val = 40'h12_3456_789A; req_valid = 1'b1; out_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check_byte("midrst", 40'h9A_7856_3412, 0);
        step();
        check_byte("midrst", 40'h9A_7856_3412, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midrst after");
        chk("midrst snap", 64'(dut_l.snap_q), 64'(40'hFF_FFFF_FFFF));
        $display("reset mid-transfer");
        run_xfer(tbl[5], "after_rst");

        // Reset and request together: reset wins.
        rst = 1'b1; req_valid = 1'b1; in_val = 40'h01_2345_6789;
        step();
        rst = 1'b0; req_valid = 1'b0;
        check_idle("rst+req");
        chk("rst+req snap", 64'(dut_l.snap_q), 64'(40'hFF_FFFF_FFFF));
        step();
        check_idle("rst+req later");
        $display("reset with simultaneous request");

        for (int i = 0; i < 30; i++) begin
            rv.val       = {8'($urandom), 32'($urandom)};
            rv.stall_at  = int'($urandom_range(0, 5));
            rv.stall_len = int'($urandom_range(1, 3));
            rv.change_in = 1'($urandom_range(0, 1));
            rv.hold_req  = 1'($urandom_range(0, 1));
            rv.exp_seq   = model_seq(rv.val);
            run_xfer(rv, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
